// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a byte-lane block RAM. The write FSM and the read FSM run
// independently; both support INCR and FIXED bursts, and errors are reported on B and R.
module axi4_slave_ram #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  // write address
  input  logic [3:0]              awid,
  input  logic [ADDR_BYTES*8-1:0] awaddr,
  input  logic [3:0]              awlen,
  input  logic [3:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [1:0]              awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [3:0]              wid,
  input  logic [DATA_BYTES*8-1:0] wdata,
  input  logic [DATA_BYTES-1:0]   wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [3:0]              bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [3:0]              arid,
  input  logic [ADDR_BYTES*8-1:0] araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [1:0]              arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [3:0]              rid,
  output logic [DATA_BYTES*8-1:0] rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int ADDR_W = ADDR_BYTES * 8;
  localparam int OFFS   = $clog2(DATA_BYTES);
  localparam int IDX_W  = ADDR_W - OFFS;
  localparam int DA_W   = $clog2(DEPTH_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e         w_state_q, w_state_d;
  logic [3:0]       bid_q;
  logic [1:0]       bresp_q;
  logic [DA_W-1:0]  waddr_q;
  logic [3:0]       wlen_q;
  logic [1:0]       wburst_q;
  logic [3:0]       wbeat_q;
  logic             wdrop_q;

  r_state_e         r_state_q, r_state_d;
  logic [3:0]       rid_q;
  logic [1:0]       rresp_q;
  logic [DA_W-1:0]  raddr_q;
  logic [3:0]       rlen_q;
  logic [1:0]       rburst_q;
  logic [3:0]       rbeat_q;

  logic unused_inputs;
  assign unused_inputs = ^{wid, awlock, awcache, awprot, arlock, arcache, arprot, awaddr, araddr};

  // Address decode: bits above the RAM index mean the burst starts outside memory.
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic [1:0]       aw_resp, ar_resp;
  assign aw_idx = awaddr[ADDR_W-1:OFFS];
  assign ar_idx = araddr[ADDR_W-1:OFFS];

  always_comb begin
    aw_resp = RESP_OKAY;
    if (|aw_idx[IDX_W-1:DA_W])
      aw_resp = RESP_DECERR;
    else if (awburst[1] || (awsize != 4'(OFFS)))
      aw_resp = RESP_SLVERR;
    ar_resp = RESP_OKAY;
    if (|ar_idx[IDX_W-1:DA_W])
      ar_resp = RESP_DECERR;
    else if (arburst[1] || (arsize != 3'(OFFS)))
      ar_resp = RESP_SLVERR;
  end

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_final, r_final;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign w_final = (wbeat_q == wlen_q);
  assign r_final = (rbeat_q == rlen_q);

  always_comb begin
    w_state_d = w_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_d = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_state_d = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      wdrop_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        bid_q    <= awid;
        bresp_q  <= aw_resp;
        waddr_q  <= aw_idx[DA_W-1:0];
        wlen_q   <= awlen;
        wburst_q <= awburst;
        wbeat_q  <= '0;
        wdrop_q  <= (aw_resp != RESP_OKAY);
      end
      if (w_hs) begin
        wbeat_q <= wbeat_q + 4'd1;
        if (wburst_q == BURST_INCR) waddr_q <= waddr_q + DA_W'(1);
        // A wlast mismatch only downgrades a clean burst; the beats are still written.
        if ((wlast != w_final) && (bresp_q == RESP_OKAY)) bresp_q <= RESP_SLVERR;
      end
    end
  end

  assign bid   = bid_q;
  assign bresp = bresp_q;

  always_comb begin
    r_state_d = r_state_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = r_final;
        if (rready && r_final) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  logic [DA_W-1:0] raddr_nxt, rd_addr;
  logic            rd_en, rd_zero;
  assign raddr_nxt = (rburst_q == BURST_INCR) ? raddr_q + DA_W'(1) : raddr_q;
  // The RAM is read one beat ahead: on AR for beat 0, on each non-final R handshake for the next.
  assign rd_en     = ar_hs || (r_hs && !r_final);
  assign rd_addr   = ar_hs ? ar_idx[DA_W-1:0] : raddr_nxt;
  assign rd_zero   = ar_hs ? (ar_resp != RESP_OKAY) : (rresp_q != RESP_OKAY);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rid_q    <= arid;
        rresp_q  <= ar_resp;
        raddr_q  <= ar_idx[DA_W-1:0];
        rlen_q   <= arlen;
        rburst_q <= arburst;
        rbeat_q  <= '0;
      end else if (r_hs && !r_final) begin
        rbeat_q <= rbeat_q + 4'd1;
        raddr_q <= raddr_nxt;
      end
    end
  end

  assign rid   = rid_q;
  assign rresp = rresp_q;

  logic mem_we;
  assign mem_we = w_hs && !wdrop_q;

  // One RAM per byte lane; the registered read returns pre-write data on a same-cycle collision.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_q;

      always_ff @(posedge aclk) begin
        if (mem_we && wstrb[gi]) mem[waddr_q] <= wdata[gi*8 +: 8];
      end

      always_ff @(posedge aclk) begin
        if (areset)
          rd_byte_q <= '0;
        else if (rd_en)
          rd_byte_q <= rd_zero ? 8'h00 : mem[rd_addr];
      end

      assign rdata[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed bench for axi4_slave_ram: a word-array memory model and response queues
// are checked against the DUT every cycle, plus literal expectations on captured beats.
module tb_axi4_slave_ram;
  localparam int DEPTH = 1024;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid, awlen, awsize, awcache;
  logic [31:0] awaddr;
  logic [1:0]  awburst, awlock;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi4_slave_ram #(.DATA_BYTES(4), .ADDR_BYTES(4), .DEPTH_WORDS(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endfunction

  task automatic fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // Behavioural model: memory as whole words, expected responses as queues.
  logic [31:0] mm [DEPTH];
  logic [3:0]  bq_id[$];
  logic [1:0]  bq_resp[$];
  logic [31:0] rq_data[$];
  logic [3:0]  rq_id[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  logic [31:0] rcap[$];
  logic [1:0]  last_bresp;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  function automatic logic [1:0] decode(logic [31:0] addr, logic [3:0] size, logic [1:0] burst);
    if ((addr >> 2) >= DEPTH) return 2'b11;
    if (burst > 2'd1 || size != 4'd2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_beats(int len);
    for (int k = 0; k < 16; k++) begin
      ws[k] = 4'hF;
      wl[k] = (k == len);
      wd[k] = 32'h0;
    end
  endtask

  task automatic model_write(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                             logic [3:0] size, logic [1:0] burst);
    logic [1:0] resp;
    bit         drop;
    int         a;
    resp = decode(addr, size, burst);
    drop = (resp != 2'b00);
    a    = int'((addr >> 2) % DEPTH);
    for (int k = 0; k <= int'(len); k++) begin
      if ((wl[k] != (k == int'(len))) && resp == 2'b00) resp = 2'b10;
      if (!drop)
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) mm[a][8*b +: 8] = wd[k][8*b +: 8];
      if (burst == 2'b01) a = (a + 1) % DEPTH;
    end
    bq_id.push_back(id);
    bq_resp.push_back(resp);
  endtask

  task automatic model_read(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                            logic [3:0] size, logic [1:0] burst);
    logic [1:0] resp;
    int         a;
    resp = decode(addr, size, burst);
    a    = int'((addr >> 2) % DEPTH);
    for (int k = 0; k <= int'(len); k++) begin
      rq_data.push_back(resp == 2'b00 ? mm[a] : 32'h0);
      rq_id.push_back(id);
      rq_resp.push_back(resp);
      rq_last.push_back(k == int'(len));
      if (burst == 2'b01) a = (a + 1) % DEPTH;
    end
  endtask

  // Compare process: every cycle on the falling edge.
  bit          r_hold = 0, b_hold = 0;
  logic [31:0] prev_rdata;
  logic        prev_rlast;
  logic [3:0]  prev_bid;
  logic [1:0]  prev_bresp;

  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid) begin
        if (rq_data.size() == 0) fail_now("r_unexpected_beat");
        else begin
          chk("rdata", rdata, rq_data[0]);
          chk("rid", 32'(rid), 32'(rq_id[0]));
          chk("rresp", 32'(rresp), 32'(rq_resp[0]));
          chk("rlast", 32'(rlast), 32'(rq_last[0]));
          if (rready) begin
            rcap.push_back(rdata);
            void'(rq_data.pop_front());
            void'(rq_id.pop_front());
            void'(rq_resp.pop_front());
            void'(rq_last.pop_front());
          end
        end
        if (r_hold) begin
          chk("rdata_stable", rdata, prev_rdata);
          chk("rlast_stable", 32'(rlast), 32'(prev_rlast));
        end
      end else chk("rlast_idle", 32'(rlast), 32'h0);
      if (bvalid) begin
        if (bq_id.size() == 0) fail_now("b_unexpected");
        else begin
          chk("bid", 32'(bid), 32'(bq_id[0]));
          chk("bresp", 32'(bresp), 32'(bq_resp[0]));
          if (bready) begin
            last_bresp = bresp;
            void'(bq_id.pop_front());
            void'(bq_resp.pop_front());
          end
        end
        if (b_hold) begin
          chk("bid_stable", 32'(bid), 32'(prev_bid));
          chk("bresp_stable", 32'(bresp), 32'(prev_bresp));
        end
      end
      r_hold     = rvalid && !rready;
      b_hold     = bvalid && !bready;
      prev_rdata = rdata;
      prev_rlast = rlast;
      prev_bid   = bid;
      prev_bresp = bresp;
    end else begin
      r_hold = 0;
      b_hold = 0;
    end
  end

  // Drivers: every task is entered and left one time unit after a rising edge.
  task automatic drive_aw(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                          logic [3:0] size, logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!awready && n < 50);
    if (!awready) fail_now("aw_timeout");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic drive_w(int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int n = 0;
      wdata = wd[k]; wstrb = ws[k]; wlast = wl[k]; wid = 4'hF - 4'(k); wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!wready && n < 50);
      if (!wready) fail_now("w_timeout");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b_done();
    int n = 0;
    while (bq_id.size() != 0 && n < 100) begin @(posedge aclk); n++; end
    #1;
    if (bq_id.size() != 0) fail_now("b_timeout");
  endtask

  task automatic drain_r(bit toggle);
    int c = 0;
    while (rq_data.size() != 0 && c < 200) begin
      rready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge aclk);
      if (c == 0) chk("r_first_beat_valid", 32'(rvalid), 32'h1);
      @(posedge aclk); #1;
      c++;
    end
    rready = 1'b1;
    if (rq_data.size() != 0) fail_now("r_timeout");
  endtask

  task automatic do_write(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                          logic [3:0] size, logic [1:0] burst, int bstall);
    @(posedge aclk); #1;
    bready = (bstall == 0);
    model_write(id, addr, len, size, burst);
    drive_aw(id, addr, len, size, burst);
    drive_w(int'(len) + 1);
    if (bstall > 0) begin
      repeat (bstall) @(posedge aclk);
      #1 bready = 1'b1;
    end
    wait_b_done();
  endtask

  task automatic do_read(logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                         logic [3:0] size, logic [1:0] burst, bit toggle);
    int n = 0;
    @(posedge aclk); #1;
    rcap.delete();
    model_read(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size[2:0]; arburst = burst; arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!arready && n < 50);
    if (!arready) fail_now("ar_timeout");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    drain_r(toggle);
  endtask

  initial begin
    #500000;
    fail_now("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    areset = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 2'b11; awcache = 4'hF;
    awprot = 3'h7; awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    bready = 1; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 2'b11;
    arcache = 4'hF; arprot = 3'h7; arvalid = 0; rready = 1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 32'(awready), 32'h1);
    chk("rst_arready", 32'(arready), 32'h1);
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rlast", 32'(rlast), 32'h0);
    chk("rst_resps", 32'({bresp, rresp}), 32'h0);
    chk("rst_ids", 32'({bid, rid}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Fill the whole RAM with a known pattern through 16-beat INCR bursts.
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      set_beats(15);
      for (int k = 0; k < 16; k++) wd[k] = 32'hC0DE_0000 | 32'(blk * 16 + k);
      do_write(4'(blk), 32'(blk * 64), 4'd15, 4'd2, 2'b01, 0);
    end

    // INCR write then read back at 0x10.
    set_beats(3);
    for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + 32'(k);
    do_write(4'h3, 32'h10, 4'd3, 4'd2, 2'b01, 0);
    chk("incr_bresp", 32'(last_bresp), 32'h0);
    do_read(4'h9, 32'h10, 4'd3, 4'd2, 2'b01, 0);
    chk("incr_beats", 32'(rcap.size()), 32'd4);
    chk("incr_beat0", rcap[0], 32'hA0);
    chk("incr_beat3", rcap[3], 32'hA3);

    // Byte strobes on word 5, with a stalled B channel.
    set_beats(0);
    wd[0] = 32'h1122_3344;
    do_write(4'h1, 32'd20, 4'd0, 4'd2, 2'b01, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
    do_write(4'h2, 32'd20, 4'd0, 4'd2, 2'b01, 3);
    do_read(4'h4, 32'd20, 4'd0, 4'd2, 2'b01, 0);
    chk("strobe_merge", rcap[0], 32'h11FF_33FF);

    // FIXED burst to word 7.
    set_beats(2);
    wd[0] = 1; wd[1] = 2; wd[2] = 3;
    do_write(4'h5, 32'd28, 4'd2, 4'd2, 2'b00, 0);
    do_read(4'h6, 32'd28, 4'd1, 4'd2, 2'b01, 0);
    chk("fixed_word7", rcap[0], 32'h3);
    chk("fixed_word8", rcap[1], 32'hC0DE_0008);

    // Error responses on writes.
    set_beats(1);
    wd[0] = 32'hDEAD_0000; wd[1] = 32'hDEAD_0001;
    do_write(4'h7, 32'h1000, 4'd1, 4'd2, 2'b01, 0);
    chk("decerr_bresp", 32'(last_bresp), 32'h3);
    do_read(4'h8, 32'h0, 4'd1, 4'd2, 2'b01, 0);
    chk("decerr_nowrite", rcap[0], 32'hC0DE_0000);
    do_write(4'h9, 32'd160, 4'd1, 4'd2, 2'b11, 0);
    chk("burst11_bresp", 32'(last_bresp), 32'h2);
    do_write(4'hA, 32'd160, 4'd1, 4'd1, 2'b01, 0);
    do_read(4'hA, 32'd160, 4'd1, 4'd2, 2'b01, 0);
    chk("slverr_nowrite", rcap[0], 32'hC0DE_0028);
    set_beats(1);
    wl[0] = 1'b1;
    wd[0] = 32'h5A5A_0000; wd[1] = 32'h5A5A_0001;
    do_write(4'hB, 32'd200, 4'd1, 4'd2, 2'b01, 0);
    chk("early_wlast_bresp", 32'(last_bresp), 32'h2);
    do_read(4'hC, 32'd200, 4'd1, 4'd2, 2'b01, 0);
    chk("early_wlast_beat1", rcap[1], 32'h5A5A_0001);
    set_beats(1);
    wl[1] = 1'b0;
    wd[0] = 32'h6B6B_0000; wd[1] = 32'h6B6B_0001;
    do_write(4'hD, 32'd240, 4'd1, 4'd2, 2'b01, 0);

    // Error responses on reads.
    do_read(4'hD, 32'h1000, 4'd2, 4'd2, 2'b01, 0);
    do_read(4'hE, 32'h0, 4'd1, 4'd2, 2'b10, 0);
    do_read(4'hF, 32'h0, 4'd0, 4'd1, 2'b01, 0);

    // Wrap from the top word to word 0 on both channels.
    set_beats(3);
    for (int k = 0; k < 4; k++) wd[k] = 32'h7777_0000 + 32'(k);
    do_write(4'h1, 32'(1022 * 4), 4'd3, 4'd2, 2'b01, 0);
    do_read(4'h2, 32'(1022 * 4), 4'd3, 4'd2, 2'b01, 0);
    do_read(4'h3, 32'h0, 4'd0, 4'd2, 2'b01, 0);
    chk("wrap_word0", rcap[0], 32'h7777_0002);

    // 8-beat read with rready toggling.
    do_read(4'h3, 32'h100, 4'd7, 4'd2, 2'b01, 1);
    chk("toggle_beats", 32'(rcap.size()), 32'd8);
    chk("toggle_beat7", rcap[7], 32'hC0DE_0047);

    // Read and write of word 90 committed on the same edge.
    @(posedge aclk); #1;
    rcap.delete();
    model_read(4'h1, 32'd360, 4'd0, 4'd2, 2'b01);
    set_beats(0);
    wd[0] = 32'h0BAD_F00D;
    model_write(4'h2, 32'd360, 4'd0, 4'd2, 2'b01);
    bready = 1'b1;
    drive_aw(4'h2, 32'd360, 4'd0, 4'd2, 2'b01);
    wdata = wd[0]; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'h1; araddr = 32'd360; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    chk("collide_wready", 32'(wready), 32'h1);
    chk("collide_arready", 32'(arready), 32'h1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    drain_r(0);
    wait_b_done();
    chk("collide_old_data", rcap[0], 32'hC0DE_005A);
    do_read(4'h3, 32'd360, 4'd0, 4'd2, 2'b01, 0);
    chk("collide_new_data", rcap[0], 32'h0BAD_F00D);

    // Reset in the middle of a 4-beat burst to word 30.
    @(posedge aclk); #1;
    set_beats(3);
    for (int k = 0; k < 4; k++) wd[k] = 32'hE0 + 32'(k);
    drive_aw(4'h4, 32'd120, 4'd3, 4'd2, 2'b01);
    drive_w(2);
    mm[30] = wd[0];
    mm[31] = wd[1];
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("midrst_awready", 32'(awready), 32'h1);
    chk("midrst_wready", 32'(wready), 32'h0);
    chk("midrst_bvalid", 32'(bvalid), 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    do_read(4'h5, 32'd120, 4'd3, 4'd2, 2'b01, 0);
    chk("midrst_beat0", rcap[0], 32'hE0);
    chk("midrst_beat1", rcap[1], 32'hE1);
    chk("midrst_beat2", rcap[2], 32'hC0DE_0020);

    repeat (4) @(posedge aclk);
    chk("r_queue_drained", 32'(rq_data.size()), 32'h0);
    chk("b_queue_drained", 32'(bq_id.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_slave_ram.md
AXI4_SLAVE_RAM -- requirements
Module: axi4_slave_ram

Interface
- REQ-001: The block SHALL have parameter DATA_BYTES, default 4, meaning the data bus width in bytes (power of two, 1..16).
- REQ-002: The block SHALL have parameter ADDR_BYTES, default 4, meaning the address bus width in bytes.
- REQ-003: The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the memory depth in data words (power of two).
- REQ-004: The block SHALL have port aclk, input, width 1: the single clock; all logic is on its rising edge.
- REQ-005: The block SHALL have port areset, input, width 1: reset, synchronous and active-high.
- REQ-006: The block SHALL have the write-address inputs awid[3:0], awaddr[ADDR_BYTES*8-1:0], awlen[3:0], awsize[3:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0] and awvalid, plus the output awready.
- REQ-007: The block SHALL have the write-data inputs wid[3:0], wdata[DATA_BYTES*8-1:0], wstrb[DATA_BYTES-1:0], wlast and wvalid, plus the output wready.
- REQ-008: The block SHALL have the write-response outputs bid[3:0], bresp[1:0] and bvalid, plus the input bready.
- REQ-009: The block SHALL have the read-address inputs arid[3:0], araddr, arlen[3:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0] and arvalid, plus the output arready.
- REQ-010: The block SHALL have the read-data outputs rid[3:0], rdata[DATA_BYTES*8-1:0], rresp[1:0], rlast and rvalid, plus the input rready.
- REQ-011: The block SHALL ignore wid, awlock, awcache, awprot, arlock, arcache and arprot.

Function
- REQ-012: The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready = (state==W_IDLE), wready = (state==W_DATA), bvalid = (state==W_RESP).
- REQ-013: On an AW handshake the block SHALL latch id, the word index (awaddr >> log2(DATA_BYTES), low bits ignored), len and burst, clear the beat counter, and go to W_DATA.
- REQ-014: Each W handshake SHALL write the byte lanes enabled by wstrb to the current word and leave the other lanes unchanged.
- REQ-015: After each beat, an INCR burst (01) SHALL increment the word index modulo DEPTH_WORDS, and a FIXED burst (00) SHALL hold it.
- REQ-016: A W_DATA burst SHALL terminate on the beat where beat counter == len (len+1 beats in total), regardless of wlast, and then go to W_RESP.
- REQ-017: A wlast mismatch (asserted early, or deasserted on the final beat) SHALL make bresp SLVERR (10), and the writes SHALL still be performed.
- REQ-018: An awburst of 10 or 11, or an awsize != log2(DATA_BYTES), SHALL give bresp SLVERR; all beats are still consumed and no memory is written.
- REQ-019: A start word index >= DEPTH_WORDS (address beyond memory) SHALL give bresp DECERR (11) with no writes; DECERR takes priority over SLVERR.
- REQ-020: Otherwise bresp SHALL be OKAY (00), and bid SHALL equal the latched awid.
- REQ-021: The block SHALL return from W_RESP to W_IDLE on bready; bid and bresp SHALL remain stable while bvalid is high and bready is low.
- REQ-022: The read FSM SHALL have states R_IDLE and R_DATA; arready = (state==R_IDLE) and rvalid = (state==R_DATA).
- REQ-023: After an AR handshake in cycle T, rvalid SHALL be high from cycle T+1 with beat 0 data; each later beat SHALL follow one cycle after each R handshake, giving one beat per cycle at full throughput.
- REQ-024: rdata, rid, rresp and rlast SHALL remain stable while rvalid is high and rready is low.
- REQ-025: rlast SHALL be high only on beat arlen; the block SHALL return to R_IDLE on the R handshake of that beat.
- REQ-026: Read errors SHALL follow the write rules (DECERR for out-of-range, SLVERR for bad burst or size), with rresp driven on every beat and rdata = 0 on error bursts.
- REQ-027: The read and write channels SHALL operate concurrently and independently.
- REQ-028: A read and a write to the same word committed in the same cycle SHALL return the old (pre-write) data.
- REQ-029: Address increment SHALL wrap from word DEPTH_WORDS-1 to word 0 within a burst.

Reset
- REQ-030: While areset is high at a clock edge, both FSMs SHALL go to their IDLE states, and all counters and latched fields SHALL clear to 0.
- REQ-031: Reset outputs SHALL be: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, bid=rid=0, rdata=0.
- REQ-032: Memory contents SHALL NOT be cleared by reset; a reset mid-burst SHALL abandon the burst with no response and keep all writes completed before reset.

Verification
- REQ-033: Write INCR awaddr=0x10, awlen=3, wdata 0xA0..0xA3 with wstrb=F, then read araddr=0x10, arlen=3 -> bresp=00; rdata=0xA0,0xA1,0xA2,0xA3 with rlast only on the 4th beat and rid=arid.
- REQ-034: Write 0x11223344 to word 5, then single-beat write 0xFFFFFFFF with wstrb=0101 -> readback of word 5 = 0x11FF33FF.
- REQ-035: FIXED write awlen=2 with data 1,2,3 to word 7 -> word 7 = 3 and word 8 unchanged.
- REQ-036: Write to awaddr=DEPTH_WORDS*4 -> bresp=11 with memory unchanged; awburst=11 -> bresp=10; wlast on beat 0 of awlen=1 -> bresp=10 and both beats written.
- REQ-037: Read awlen=7 while rready is toggled 1010... -> rdata is stable while rvalid=1 and rready=0; 8 beats in order.
- REQ-038: Assert areset while W_DATA is at beat 2 of 4 -> next cycle awready=1, wready=0, bvalid=0; beats 0-1 persist in memory.
